qspi_fetch_arbiter: RTL and testbench
=====================================

Name: qspi_fetch_arbiter

Overview:
Shares the single QSPI flash read port between two requesters.
- Port A: the game controller's word-list/trie fetches. Fire-and-forget `a_fetch` pulse; the result is read later from a held register.
- Port B: a req/gnt/valid requester, e.g. a future font/tile fetcher.
- Sits between the requesters and the QSPI controller. Serialises requests, gives A priority, and protects B from starvation with a bounded counter.

Parameters:
ADDR_W, 24, flash byte address width
DATA_W, 32, read word width
STARVE_MAX, 3, consecutive A grants allowed while B waits before B is forced through (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
a_fetch  input  1  single-cycle A request pulse
a_addr  input  ADDR_W  A address, sampled with a_fetch
a_result  output  DATA_W  last completed A read word, held
a_dropped  output  1  pulse: a pending A request was overwritten
b_req  input  1  B request level; b_addr stable while high
b_addr  input  ADDR_W  B address
b_gnt  output  1  pulse: B request accepted (issued)
b_valid  output  1  pulse: b_data valid
b_data  output  DATA_W  B read word
q_ready  input  1  QSPI controller idle, can accept start
q_start  output  1  single-cycle start pulse
q_addr  output  ADDR_W  address to QSPI, held from q_start until q_done
q_done  input  1  pulse: q_data valid, transaction ended
q_data  input  DATA_W  QSPI read word

Behaviour:
- Reset (sync, checked first): state IDLE, A pending slot empty, starve count 0.
  - All outputs 0, including a_result, b_data and q_addr.
  - A q_done arriving in IDLE (stray, e.g. after reset mid-transaction) is ignored.
- A pending slot, 1-deep:
  - a_fetch in any state latches a_addr and sets a_pend.
  - If a_pend is already set and not consumed this cycle, the new address replaces the old, and a_dropped pulses the next cycle.
  - If a_fetch arrives in the same cycle the slot is consumed, the slot refills with the new request; no drop.
- States: IDLE, WAIT.
- IDLE:
  - Each cycle, if q_ready and (a_pend or a_fetch or b_req), pick a winner.
    - Default: A wins.
    - B wins if b_req and starve_cnt == STARVE_MAX, or if no A request is present.
  - A same-cycle a_fetch counts as present and is bypassed straight to issue, without being latched first.
  - Registered outputs on the next edge: q_start=1, q_addr=winner address, owner flag, go to WAIT.
    - A win clears a_pend.
    - B win pulses b_gnt in the same cycle as q_start.
  - Issue latency: a_fetch at cycle t, IDLE and q_ready → q_start at t+1.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each A win while b_req is high.
  - Cleared on a B win, or whenever b_req is low.
- WAIT:
  - q_start low; q_addr held.
  - On q_done:
    - owner A: a_result <= q_data.
    - owner B: b_data <= q_data, b_valid=1 for one cycle.
  - Then return to IDLE. The next q_start is no earlier than the cycle after q_done's effect (t_done+2).
- a_result changes only on an A completion. b_data is held between completions.
- B must keep b_req high until b_gnt. After b_gnt, B may drop b_req or present the next address; a still-high b_req counts as a new request.
- q_ready low in IDLE: requests wait, a_pend accumulates per the overwrite rule.
- Widths: starve_cnt is 4 bits; no other arithmetic.

Test Plan:
- Idle, q_ready=1, a_fetch with a_addr=0x002000 at t → q_start at t+1 with q_addr=0x002000; q_done with q_data=0xDEADBEEF at t+5 → a_result=0xDEADBEEF at t+6, b_valid stays 0.
- b_req high with b_addr=0x040010, no A traffic → b_gnt and q_start in the same cycle with q_addr=0x040010; after q_done with 0x12345678 → b_valid pulse, b_data=0x12345678, a_result unchanged.
- b_req held high, a_fetch every transaction, STARVE_MAX=3 → grant sequence A,A,A,B,A,A,A,B; starve_cnt returns to 0 after each B grant.
- While in WAIT, two a_fetch pulses with 0x1000 then 0x2000 → a_dropped pulses once; next A issue uses q_addr=0x2000; exactly one extra q_start.
- Reset asserted mid-WAIT, then q_done arrives after reset → all outputs 0, no a_result/b_valid update, next a_fetch issues normally.
- q_ready held low for 10 cycles with a_pend set and b_req high, starve_cnt=0 → no q_start while low; A issues on the first cycle q_ready=1.

Source files
------------

// File: rtl/qspi_fetch_arbiter_if.sv
// Signal bundle between the two flash requesters, the arbiter and the QSPI read controller.
// The arbiter connects through the slave modport; the requester/controller side uses master.
interface qspi_fetch_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              a_fetch;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_result;
  logic              a_dropped;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_gnt;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;

  logic              q_ready;
  logic              q_start;
  logic [ADDR_W-1:0] q_addr;
  logic              q_done;
  logic [DATA_W-1:0] q_data;

  modport slave (
    input  a_fetch, a_addr, b_req, b_addr, q_ready, q_done, q_data,
    output a_result, a_dropped, b_gnt, b_valid, b_data, q_start, q_addr
  );

  modport master (
    output a_fetch, a_addr, b_req, b_addr, q_ready, q_done, q_data,
    input  a_result, a_dropped, b_gnt, b_valid, b_data, q_start, q_addr
  );
endinterface

// File: rtl/qspi_fetch_arbiter.sv
// Shares one QSPI read port between a fire-and-forget fetcher (A, priority) and a
// req/gnt/valid fetcher (B), with a bounded run of A grants while B is waiting.
//
// state | meaning
// IDLE  | no transaction outstanding; picks a winner when q_ready
// WAIT  | transaction issued; waiting for q_done to route the read word
module qspi_fetch_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  qspi_fetch_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, state_nxt;
  logic              a_pend, a_pend_nxt;
  logic [ADDR_W-1:0] a_pend_addr, a_pend_addr_nxt;
  logic [3:0]        starve_cnt, starve_cnt_nxt;
  logic              owner_b, owner_b_nxt;
  logic              q_start, q_start_nxt;
  logic [ADDR_W-1:0] q_addr, q_addr_nxt;
  logic [DATA_W-1:0] a_result, a_result_nxt;
  logic [DATA_W-1:0] b_data, b_data_nxt;
  logic              a_dropped, a_dropped_nxt;
  logic              b_gnt, b_gnt_nxt;
  logic              b_valid, b_valid_nxt;

  logic a_avail;
  logic b_wins;
  logic consume;
  logic bypass;

  always_comb begin
    state_nxt       = state;
    a_pend_nxt      = a_pend;
    a_pend_addr_nxt = a_pend_addr;
    starve_cnt_nxt  = starve_cnt;
    owner_b_nxt     = owner_b;
    q_start_nxt     = 1'b0;
    q_addr_nxt      = q_addr;
    a_result_nxt    = a_result;
    b_data_nxt      = b_data;
    a_dropped_nxt   = 1'b0;
    b_gnt_nxt       = 1'b0;
    b_valid_nxt     = 1'b0;
    consume         = 1'b0;
    bypass          = 1'b0;

    a_avail = a_pend | bus.a_fetch;
    b_wins  = bus.b_req & ((starve_cnt == STARVE_LIM) | ~a_avail);

    case (state)
      IDLE: begin
        if (bus.q_ready && (a_avail || bus.b_req)) begin
          state_nxt   = WAIT;
          q_start_nxt = 1'b1;
          if (b_wins) begin
            owner_b_nxt    = 1'b1;
            q_addr_nxt     = bus.b_addr;
            b_gnt_nxt      = 1'b1;
            starve_cnt_nxt = 4'd0;
          end else begin
            // Oldest A request goes first; a same-cycle fetch only bypasses an empty slot.
            owner_b_nxt = 1'b0;
            q_addr_nxt  = a_pend ? a_pend_addr : bus.a_addr;
            consume     = a_pend;
            bypass      = ~a_pend;
            if (bus.b_req && (starve_cnt != STARVE_LIM))
              starve_cnt_nxt = starve_cnt + 4'd1;
          end
        end
      end
      WAIT: begin
        if (bus.q_done) begin
          state_nxt = IDLE;
          if (owner_b) begin
            b_data_nxt  = bus.q_data;
            b_valid_nxt = 1'b1;
          end else begin
            a_result_nxt = bus.q_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!bus.b_req)
      starve_cnt_nxt = 4'd0;

    if (consume)
      a_pend_nxt = 1'b0;

    // A fetch not bypassed to issue lands in the slot, overwriting any unconsumed entry.
    if (bus.a_fetch && !bypass) begin
      a_pend_nxt      = 1'b1;
      a_pend_addr_nxt = bus.a_addr;
      a_dropped_nxt   = a_pend & ~consume;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_pend      <= 1'b0;
      a_pend_addr <= '0;
      starve_cnt  <= 4'd0;
      owner_b     <= 1'b0;
      q_start     <= 1'b0;
      q_addr      <= '0;
      a_result    <= '0;
      b_data      <= '0;
      a_dropped   <= 1'b0;
      b_gnt       <= 1'b0;
      b_valid     <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_pend      <= a_pend_nxt;
      a_pend_addr <= a_pend_addr_nxt;
      starve_cnt  <= starve_cnt_nxt;
      owner_b     <= owner_b_nxt;
      q_start     <= q_start_nxt;
      q_addr      <= q_addr_nxt;
      a_result    <= a_result_nxt;
      b_data      <= b_data_nxt;
      a_dropped   <= a_dropped_nxt;
      b_gnt       <= b_gnt_nxt;
      b_valid     <= b_valid_nxt;
    end
  end

  assign bus.q_start   = q_start;
  assign bus.q_addr    = q_addr;
  assign bus.a_result  = a_result;
  assign bus.a_dropped = a_dropped;
  assign bus.b_gnt     = b_gnt;
  assign bus.b_valid   = b_valid;
  assign bus.b_data    = b_data;

endmodule

// File: tb/tb_qspi_fetch_arbiter.sv
// Bench for qspi_fetch_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level reference model.
module tb_qspi_fetch_arbiter;
  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qspi_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  qspi_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_qs     = 0;

  // reference model: busy flag, owner, 1-deep A mailbox, run length of A grants while B waits
  bit                m_busy = 0;
  bit                m_own_b = 0;
  logic [ADDR_W-1:0] m_pend[$];
  int                m_streak = 0;

  bit                e_qstart = 0, e_bgnt = 0, e_bvalid = 0, e_adrop = 0;
  logic [ADDR_W-1:0] e_qaddr = '0;
  logic [DATA_W-1:0] e_aresult = '0, e_bdata = '0;

  // flash responder used during the random phase
  bit fl_busy = 0;
  int fl_cnt  = 0;
  int pf = 25, pb = 30, pnr = 20, lat_max = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval_model();
    bit a_avail, used_fetch, b_win;
    e_qstart = 0; e_bgnt = 0; e_bvalid = 0; e_adrop = 0;
    used_fetch = 0;
    if (!rst_n) begin
      m_busy = 0; m_own_b = 0; m_pend.delete(); m_streak = 0;
      e_qaddr = '0; e_aresult = '0; e_bdata = '0;
      return;
    end
    if (!m_busy) begin
      a_avail = (m_pend.size() > 0) || bus.a_fetch;
      if (bus.q_ready && (a_avail || bus.b_req)) begin
        b_win = bus.b_req && (m_streak >= STARVE_MAX || !a_avail);
        m_busy = 1; m_own_b = b_win; e_qstart = 1;
        if (b_win) begin
          e_qaddr = bus.b_addr; e_bgnt = 1; m_streak = 0;
        end else begin
          if (m_pend.size() > 0) e_qaddr = m_pend.pop_front();
          else begin e_qaddr = bus.a_addr; used_fetch = 1; end
          if (bus.b_req) m_streak++;
        end
      end
    end else if (bus.q_done) begin
      m_busy = 0;
      if (m_own_b) begin e_bdata = bus.q_data; e_bvalid = 1; end
      else e_aresult = bus.q_data;
    end
    if (!bus.b_req) m_streak = 0;
    if (bus.a_fetch && !used_fetch) begin
      if (m_pend.size() > 0) begin e_adrop = 1; void'(m_pend.pop_front()); end
      m_pend.push_back(bus.a_addr);
    end
  endtask

  task automatic edge_check();
    @(posedge clk); #1;
    check("q_start",   32'(bus.q_start),   32'(e_qstart));
    check("q_addr",    32'(bus.q_addr),    32'(e_qaddr));
    check("b_gnt",     32'(bus.b_gnt),     32'(e_bgnt));
    check("b_valid",   32'(bus.b_valid),   32'(e_bvalid));
    check("b_data",    bus.b_data,         e_bdata);
    check("a_result",  bus.a_result,       e_aresult);
    check("a_dropped", 32'(bus.a_dropped), 32'(e_adrop));
    if (bus.q_start) n_qs++;
  endtask

  task automatic idle_in();
    rst_n       = 1'b1;
    bus.a_fetch = 1'b0;
    bus.a_addr  = '0;
    bus.b_req   = 1'b0;
    bus.b_addr  = '0;
    bus.q_ready = 1'b1;
    bus.q_done  = 1'b0;
    bus.q_data  = DATA_W'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      edge_check(); idle_in(); eval_model();
    end
  endtask

  task automatic env_random();
    rst_n = ($urandom_range(0, 599) != 0);
    bus.q_done = 1'b0;
    bus.q_data = DATA_W'($urandom);
    if (bus.q_start) begin
      fl_busy = 1; fl_cnt = $urandom_range(1, lat_max);
    end else if (fl_busy) begin
      fl_cnt--;
      if (fl_cnt == 0) begin bus.q_done = 1'b1; fl_busy = 0; end
    end
    bus.q_ready = !fl_busy && ($urandom_range(0, 99) >= pnr);
    if (bus.b_req && bus.b_gnt) begin
      if ($urandom_range(0, 1) == 0) bus.b_addr = ADDR_W'($urandom);
      else bus.b_req = 1'b0;
    end else if (!bus.b_req && $urandom_range(0, 99) < pb) begin
      bus.b_req  = 1'b1;
      bus.b_addr = ADDR_W'($urandom);
    end
    bus.a_fetch = ($urandom_range(0, 99) < pf);
    bus.a_addr  = ADDR_W'($urandom);
  endtask

  initial begin
    int qs0;
    logic [7:0] grants;

    idle_in(); rst_n = 1'b0; eval_model();
    for (int i = 0; i < 3; i++) begin
      edge_check(); idle_in(); rst_n = 1'b0; eval_model();
    end
    edge_check(); idle_in(); eval_model();

    // A fetch: issue next cycle, result after completion
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h002000; eval_model();
    edge_check(); idle_in(); eval_model();
    check("t1_qstart", 32'(bus.q_start), 32'd1);
    check("t1_qaddr", 32'(bus.q_addr), 32'h002000);
    idle_cycles(3);
    edge_check(); idle_in(); bus.q_done = 1; bus.q_data = 32'hDEADBEEF; eval_model();
    edge_check(); idle_in(); eval_model();
    check("t1_result", bus.a_result, 32'hDEADBEEF);
    check("t1_bvalid", 32'(bus.b_valid), 32'd0);

    // B alone
    edge_check(); idle_in(); bus.b_req = 1; bus.b_addr = 24'h040010; eval_model();
    edge_check(); idle_in(); eval_model();
    check("t2_gnt", 32'(bus.b_gnt), 32'd1);
    check("t2_qaddr", 32'(bus.q_addr), 32'h040010);
    edge_check(); idle_in(); bus.q_done = 1; bus.q_data = 32'h12345678; eval_model();
    edge_check(); idle_in(); eval_model();
    check("t2_bvalid", 32'(bus.b_valid), 32'd1);
    check("t2_bdata", bus.b_data, 32'h12345678);
    check("t2_result", bus.a_result, 32'hDEADBEEF);

    // starvation bound with B always requesting and A fetching each transaction
    grants = '0;
    for (int t = 0; t < 8; t++) begin
      edge_check(); idle_in();
      bus.a_fetch = 1; bus.a_addr = ADDR_W'($urandom);
      bus.b_req = 1; bus.b_addr = 24'h007000;
      eval_model();
      edge_check(); idle_in();
      grants[t] = bus.b_gnt;
      bus.b_req = 1; bus.b_addr = 24'h007000;
      bus.q_done = 1;
      eval_model();
    end
    check("t3_grants", 32'(grants), 32'h88);
    edge_check(); idle_in(); eval_model();
    edge_check(); idle_in(); bus.q_done = 1; eval_model();
    idle_cycles(1);

    // overwrite of the pending A slot during WAIT
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h00AAAA; eval_model();
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h001000; eval_model();
    qs0 = n_qs;
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h002000; eval_model();
    edge_check(); idle_in(); bus.q_done = 1; eval_model();
    check("t4_drop", 32'(bus.a_dropped), 32'd1);
    edge_check(); idle_in(); eval_model();
    edge_check(); idle_in(); eval_model();
    check("t4_qaddr", 32'(bus.q_addr), 32'h002000);
    edge_check(); idle_in(); bus.q_done = 1; eval_model();
    idle_cycles(3);
    check("t4_nstart", 32'(n_qs - qs0), 32'd1);

    // reset during WAIT, then a stray completion
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h003333; eval_model();
    edge_check(); idle_in(); rst_n = 1'b0; eval_model();
    edge_check(); idle_in(); bus.q_done = 1; bus.q_data = 32'h55555555; eval_model();
    check("t5_rst_result", bus.a_result, 32'h0);
    edge_check(); idle_in(); bus.a_fetch = 1; bus.a_addr = 24'h004444; eval_model();
    check("t5_stray", bus.a_result, 32'h0);
    edge_check(); idle_in(); eval_model();
    check("t5_reissue", 32'(bus.q_addr), 32'h004444);
    edge_check(); idle_in(); bus.q_done = 1; eval_model();

    // q_ready low for 10 cycles with A pending and B requesting
    qs0 = n_qs;
    edge_check(); idle_in(); bus.q_ready = 0; bus.a_fetch = 1; bus.a_addr = 24'h005000;
    bus.b_req = 1; bus.b_addr = 24'h006000; eval_model();
    for (int i = 0; i < 9; i++) begin
      edge_check(); idle_in(); bus.q_ready = 0; bus.b_req = 1; bus.b_addr = 24'h006000; eval_model();
    end
    edge_check(); idle_in(); bus.b_req = 1; bus.b_addr = 24'h006000; eval_model();
    check("t6_blocked", 32'(n_qs - qs0), 32'd0);
    edge_check(); idle_in(); bus.b_req = 1; bus.b_addr = 24'h006000; bus.q_done = 1; eval_model();
    check("t6_a_first", 32'(bus.q_addr), 32'h005000);
    edge_check(); idle_in(); bus.b_req = 1; bus.b_addr = 24'h006000; eval_model();
    edge_check(); idle_in(); bus.q_done = 1; eval_model();
    check("t6_b_next", 32'(bus.b_gnt), 32'd1);
    idle_cycles(2);

    // random traffic
    fl_busy = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin pf = 60; pb = 50; pnr = 40; lat_max = 6; end
      edge_check();
      env_random();
      eval_model();
    end
    edge_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
